npu_axil_regs: RTL and testbench
================================

Name: npu_axil_regs

Overview:
AXI-Lite slave that implements the NPU control/status register map at REG_CTRL..REG_DMA_LEN. It is the responder for the host's AXI-Lite initiator. It turns host writes into control pulses and configuration values for the NPU controller and DMA engine. It returns status, version, config and performance information on reads, and drives the level interrupt.

Parameters:
- AXIL_ADDR_WIDTH, 32, AXI-Lite address width; only addr[11:0] is decoded.
- AXIL_DATA_WIDTH, 32, AXI-Lite data width; fixed at 32.
- PE_ROWS, 16, reported in REG_CONFIG[7:0].
- PE_COLS, 16, reported in REG_CONFIG[15:8].

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_axil_awaddr/awvalid/awready  in/in/out  32/1/1  write address channel
- s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel
- s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
- s_axil_araddr/arvalid/arready  in/in/out  32/1/1  read address channel
- s_axil_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel
- npu_busy, npu_done_evt, npu_err_evt  in  1 each  core status level, done pulse, error pulse
- dma_busy, dma_done_evt  in  1 each  DMA status level, DMA done pulse
- npu_start, npu_soft_rst  out  1 each  single-cycle pulses
- dma_start  out  1  single-cycle pulse
- dma_src, dma_dst  out  32 each  DMA source/destination addresses
- dma_len  out  24  DMA transfer length
- irq  out  1  level interrupt

Behaviour:
- Reset: all ready, valid and pulse outputs are 0; bresp/rresp = 0; rdata = 0; all RW/W1C registers = 0; perf counter = 0; irq = 0.
- Write path:
  - awready and wready are asserted together, for one cycle, only when awvalid && wvalid && !bvalid. AW and W are never accepted separately.
  - Register update and bvalid both occur on the cycle after acceptance.
  - bvalid holds until bready.
  - wstrb applies per byte to RW registers. Pulse and W1C bits act only if their byte strobe is set.
- Read path:
  - arready is asserted for one cycle when arvalid && !rvalid.
  - rdata/rresp are registered on the next cycle and held with rvalid until rready.
- Read and write channels are independent and may complete in the same cycle.
- Unmapped offset (anything not in the map below):
  - Write is dropped, bresp = SLVERR (2'b10).
  - Read returns rdata = 0, rresp = SLVERR.
  - Mapped offsets respond OKAY (2'b00).
- Register map:
  - 0x000 CTRL (W): bit0 → npu_start pulse; bit1 → npu_soft_rst pulse. Reads as 0.
  - 0x004 STATUS (RO): {30'b0, npu_err_sticky, npu_busy}. npu_err_sticky mirrors IRQ_STATUS[1].
  - 0x008 IRQ_EN (RW): bits[2:0] = {dma_done, npu_err, npu_done}.
  - 0x00C IRQ_STATUS (W1C): bits[2:0], same order as IRQ_EN. Set by the corresponding *_evt input.
  - 0x010 VERSION (RO): 0x0001_0000.
  - 0x014 CONFIG (RO): {16'b0, PE_COLS[7:0], PE_ROWS[7:0]}.
  - 0x020 PERF_CNT: reads the 32-bit counter. Any write clears it to 0.
  - 0x100 DMA_CTRL (W): bit0 → dma_start pulse. Reads as 0.
  - 0x104 DMA_STATUS (RO): {31'b0, dma_busy}.
  - 0x108 DMA_SRC (RW, 32 bits).
  - 0x10C DMA_DST (RW, 32 bits).
  - 0x110 DMA_LEN (RW): bits[23:0]; bits[31:24] read as 0.
- Pulses: high for exactly one cycle, on the cycle the write takes effect (same cycle bvalid rises).
- IRQ_STATUS conflict: if an event and a W1C of the same bit occur in the same cycle, set wins and the bit stays 1.
- irq is registered: irq = |(IRQ_STATUS & IRQ_EN), one cycle after either register changes.
- PERF_CNT:
  - Increments by 1 each cycle npu_busy = 1 and wraps from 0xFFFF_FFFF to 0.
  - A clear-write takes priority over the increment in the same cycle.
- npu_soft_rst does not reset this block.
- Asynchronous reset mid-transaction:
  - All outstanding responses are abandoned and bvalid/rvalid drop immediately.
  - No partial register update occurs.

Test Plan:
- Read 0x010 → rdata = 0x0001_0000, rresp = OKAY. Read 0x014 with defaults → 0x0000_1010.
- Write 0x108 = 0xDEAD_BEEF with wstrb = 4'b0011, then read → 0x0000_BEEF; dma_src = 0x0000_BEEF. Write 0x110 = 0xFFFF_FFFF → reads 0x00FF_FFFF.
- Write CTRL = 0x1 → npu_start high exactly 1 cycle, coincident with bvalid. Repeat with bready held low for 5 cycles → awready stays low for a second write until B completes.
- IRQ_EN = 0x1, pulse npu_done_evt → IRQ_STATUS = 0x1, irq = 1 one cycle later. W1C 0x1 in the same cycle as a new npu_done_evt → bit stays 1. W1C alone → irq = 0.
- Hold npu_busy for 100 cycles → PERF_CNT = 100. Write 0x020 → reads 0. Preload near wrap via a long busy run → counter wraps to 0.
- Write/read 0x0FC → bresp = SLVERR, rresp = SLVERR, rdata = 0. Assert rst_n low while rvalid is pending → rvalid = 0 immediately and registers return to reset values.

Source files
------------

// File: rtl/npu_axil_regs.sv
// npu_axil_regs: AXI-Lite control/status register file for the NPU.
// Turns host writes into pulses/config and serves status reads.
module npu_axil_regs #(
   parameter int AXIL_ADDR_WIDTH = 32,
   parameter int AXIL_DATA_WIDTH = 32,
   parameter int PE_ROWS         = 16,
   parameter int PE_COLS         = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic                       s_axil_awvalid,
   output logic                       s_axil_awready,
   input  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata,
   input  logic [3:0]                 s_axil_wstrb,
   input  logic                       s_axil_wvalid,
   output logic                       s_axil_wready,
   output logic [1:0]                 s_axil_bresp,
   output logic                       s_axil_bvalid,
   input  logic                       s_axil_bready,
   input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic                       s_axil_arvalid,
   output logic                       s_axil_arready,
   output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
   output logic [1:0]                 s_axil_rresp,
   output logic                       s_axil_rvalid,
   input  logic                       s_axil_rready,
   input  logic                       npu_busy,
   input  logic                       npu_done_evt,
   input  logic                       npu_err_evt,
   input  logic                       dma_busy,
   input  logic                       dma_done_evt,
   output logic                       npu_start,
   output logic                       npu_soft_rst,
   output logic                       dma_start,
   output logic [31:0]                dma_src,
   output logic [31:0]                dma_dst,
   output logic [23:0]                dma_len,
   output logic                       irq
);

   localparam logic [11:0] A_CTRL     = 12'h000;
   localparam logic [11:0] A_STATUS   = 12'h004;
   localparam logic [11:0] A_IRQ_EN   = 12'h008;
   localparam logic [11:0] A_IRQ_ST   = 12'h00C;
   localparam logic [11:0] A_VERSION  = 12'h010;
   localparam logic [11:0] A_CONFIG   = 12'h014;
   localparam logic [11:0] A_PERF     = 12'h020;
   localparam logic [11:0] A_DMA_CTRL = 12'h100;
   localparam logic [11:0] A_DMA_STAT = 12'h104;
   localparam logic [11:0] A_DMA_SRC  = 12'h108;
   localparam logic [11:0] A_DMA_DST  = 12'h10C;
   localparam logic [11:0] A_DMA_LEN  = 12'h110;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic        r_bvalid;
   logic [1:0]  r_bresp;
   logic        r_rvalid;
   logic [1:0]  r_rresp;
   logic [31:0] r_rdata;
   logic        r_npu_start;
   logic        r_npu_soft_rst;
   logic        r_dma_start;
   logic [2:0]  r_irq_en;
   logic [2:0]  r_irq_st;
   logic        r_irq;
   logic [31:0] r_perf_cnt;
   logic [31:0] r_dma_src;
   logic [31:0] r_dma_dst;
   logic [23:0] r_dma_len;

   logic        w_wr_acc;
   logic        w_rd_acc;
   logic [11:0] w_waddr;
   logic [11:0] w_raddr;
   logic [31:0] w_wdata;
   logic [31:0] w_wmask;
   logic        w_wr_map;
   logic [31:0] w_rdata;
   logic [1:0]  w_rresp;
   logic [2:0]  w_w1c;
   logic [2:0]  w_evt;
   logic        w_unused;

   assign w_waddr  = s_axil_awaddr[11:0];
   assign w_raddr  = s_axil_araddr[11:0];
   assign w_wdata  = s_axil_wdata[31:0];
   assign w_wmask  = {{8{s_axil_wstrb[3]}}, {8{s_axil_wstrb[2]}},
                      {8{s_axil_wstrb[1]}}, {8{s_axil_wstrb[0]}}};
   assign w_unused = ^{s_axil_awaddr[AXIL_ADDR_WIDTH-1:12],
                       s_axil_araddr[AXIL_ADDR_WIDTH-1:12]};

   // AW and W are only ever taken together, and never while B is pending
   assign w_wr_acc = s_axil_awvalid & s_axil_wvalid & ~r_bvalid;
   assign w_rd_acc = s_axil_arvalid & ~r_rvalid;

   assign s_axil_awready = w_wr_acc;
   assign s_axil_wready  = w_wr_acc;
   assign s_axil_arready = w_rd_acc;
   assign s_axil_bvalid  = r_bvalid;
   assign s_axil_bresp   = r_bresp;
   assign s_axil_rvalid  = r_rvalid;
   assign s_axil_rresp   = r_rresp;
   assign s_axil_rdata   = r_rdata;
   assign npu_start      = r_npu_start;
   assign npu_soft_rst   = r_npu_soft_rst;
   assign dma_start      = r_dma_start;
   assign dma_src        = r_dma_src;
   assign dma_dst        = r_dma_dst;
   assign dma_len        = r_dma_len;
   assign irq            = r_irq;

   always_comb begin
      w_wr_map = 1'b0;
      case (w_waddr)
         A_CTRL, A_STATUS, A_IRQ_EN, A_IRQ_ST,
         A_VERSION, A_CONFIG, A_PERF, A_DMA_CTRL,
         A_DMA_STAT, A_DMA_SRC, A_DMA_DST, A_DMA_LEN:
            w_wr_map = 1'b1;
         default: w_wr_map = 1'b0;
      endcase
   end

   assign w_w1c = (w_wr_acc && w_waddr == A_IRQ_ST && s_axil_wstrb[0])
                  ? w_wdata[2:0] : 3'b000;
   assign w_evt = {dma_done_evt, npu_err_evt, npu_done_evt};

   always_comb begin
      w_rdata = 32'h0;
      w_rresp = RESP_OKAY;
      case (w_raddr)
         A_CTRL:     w_rdata = 32'h0;
         A_STATUS:   w_rdata = {30'b0, r_irq_st[1], npu_busy};
         A_IRQ_EN:   w_rdata = {29'b0, r_irq_en};
         A_IRQ_ST:   w_rdata = {29'b0, r_irq_st};
         A_VERSION:  w_rdata = 32'h0001_0000;
         A_CONFIG:   w_rdata = {16'b0, 8'(PE_COLS), 8'(PE_ROWS)};
         A_PERF:     w_rdata = r_perf_cnt;
         A_DMA_CTRL: w_rdata = 32'h0;
         A_DMA_STAT: w_rdata = {31'b0, dma_busy};
         A_DMA_SRC:  w_rdata = r_dma_src;
         A_DMA_DST:  w_rdata = r_dma_dst;
         A_DMA_LEN:  w_rdata = {8'b0, r_dma_len};
         default:    w_rresp = RESP_SLVERR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bvalid       <= 1'b0;
         r_bresp        <= RESP_OKAY;
         r_npu_start    <= 1'b0;
         r_npu_soft_rst <= 1'b0;
         r_dma_start    <= 1'b0;
         r_irq_en       <= 3'b0;
         r_dma_src      <= 32'h0;
         r_dma_dst      <= 32'h0;
         r_dma_len      <= 24'h0;
      end else begin
         r_npu_start    <= w_wr_acc && w_waddr == A_CTRL &&
                           s_axil_wstrb[0] && w_wdata[0];
         r_npu_soft_rst <= w_wr_acc && w_waddr == A_CTRL &&
                           s_axil_wstrb[0] && w_wdata[1];
         r_dma_start    <= w_wr_acc && w_waddr == A_DMA_CTRL &&
                           s_axil_wstrb[0] && w_wdata[0];
         if (r_bvalid && s_axil_bready) begin
            r_bvalid <= 1'b0;
         end else if (w_wr_acc) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_map ? RESP_OKAY : RESP_SLVERR;
         end
         if (w_wr_acc) begin
            if (w_waddr == A_IRQ_EN && s_axil_wstrb[0])
               r_irq_en <= w_wdata[2:0];
            if (w_waddr == A_DMA_SRC)
               r_dma_src <= (r_dma_src & ~w_wmask) | (w_wdata & w_wmask);
            if (w_waddr == A_DMA_DST)
               r_dma_dst <= (r_dma_dst & ~w_wmask) | (w_wdata & w_wmask);
            if (w_waddr == A_DMA_LEN)
               r_dma_len <= (r_dma_len & ~w_wmask[23:0]) |
                            (w_wdata[23:0] & w_wmask[23:0]);
         end
      end
   end

   // Event set has priority over a same-cycle W1C
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq_st   <= 3'b0;
         r_irq      <= 1'b0;
         r_perf_cnt <= 32'h0;
      end else begin
         r_irq_st <= (r_irq_st & ~w_w1c) | w_evt;
         r_irq    <= |(r_irq_st & r_irq_en);
         if (w_wr_acc && w_waddr == A_PERF)
            r_perf_cnt <= 32'h0;
         else if (npu_busy)
            r_perf_cnt <= r_perf_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvalid <= 1'b0;
         r_rresp  <= RESP_OKAY;
         r_rdata  <= 32'h0;
      end else if (r_rvalid && s_axil_rready) begin
         r_rvalid <= 1'b0;
      end else if (w_rd_acc) begin
         r_rvalid <= 1'b1;
         r_rresp  <= w_rresp;
         r_rdata  <= w_rdata;
      end
   end

endmodule

// File: tb/tb_npu_axil_regs.sv
// tb_npu_axil_regs: directed-vector bench for npu_axil_regs.
// Drives AXI-Lite transactions and checks hand-computed results.
module tb_npu_axil_regs;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] s_axil_awaddr;
   logic        s_axil_awvalid;
   logic        s_axil_awready;
   logic [31:0] s_axil_wdata;
   logic [3:0]  s_axil_wstrb;
   logic        s_axil_wvalid;
   logic        s_axil_wready;
   logic [1:0]  s_axil_bresp;
   logic        s_axil_bvalid;
   logic        s_axil_bready;
   logic [31:0] s_axil_araddr;
   logic        s_axil_arvalid;
   logic        s_axil_arready;
   logic [31:0] s_axil_rdata;
   logic [1:0]  s_axil_rresp;
   logic        s_axil_rvalid;
   logic        s_axil_rready;
   logic        npu_busy;
   logic        npu_done_evt;
   logic        npu_err_evt;
   logic        dma_busy;
   logic        dma_done_evt;
   logic        npu_start;
   logic        npu_soft_rst;
   logic        dma_start;
   logic [31:0] dma_src;
   logic [31:0] dma_dst;
   logic [23:0] dma_len;
   logic        irq;

   int n_vec = 0;
   int n_bad = 0;
   int n_start = 0;
   int n_srst = 0;
   int n_dstart = 0;
   int n_nob = 0;

   npu_axil_regs dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .s_axil_awaddr  (s_axil_awaddr),
      .s_axil_awvalid (s_axil_awvalid),
      .s_axil_awready (s_axil_awready),
      .s_axil_wdata   (s_axil_wdata),
      .s_axil_wstrb   (s_axil_wstrb),
      .s_axil_wvalid  (s_axil_wvalid),
      .s_axil_wready  (s_axil_wready),
      .s_axil_bresp   (s_axil_bresp),
      .s_axil_bvalid  (s_axil_bvalid),
      .s_axil_bready  (s_axil_bready),
      .s_axil_araddr  (s_axil_araddr),
      .s_axil_arvalid (s_axil_arvalid),
      .s_axil_arready (s_axil_arready),
      .s_axil_rdata   (s_axil_rdata),
      .s_axil_rresp   (s_axil_rresp),
      .s_axil_rvalid  (s_axil_rvalid),
      .s_axil_rready  (s_axil_rready),
      .npu_busy       (npu_busy),
      .npu_done_evt   (npu_done_evt),
      .npu_err_evt    (npu_err_evt),
      .dma_busy       (dma_busy),
      .dma_done_evt   (dma_done_evt),
      .npu_start      (npu_start),
      .npu_soft_rst   (npu_soft_rst),
      .dma_start      (dma_start),
      .dma_src        (dma_src),
      .dma_dst        (dma_dst),
      .dma_len        (dma_len),
      .irq            (irq)
   );

   always #5 clk = ~clk;

   // Pulse widths and their alignment with bvalid
   always @(negedge clk) begin
      if (npu_start)    n_start++;
      if (npu_soft_rst) n_srst++;
      if (dma_start)    n_dstart++;
      if ((npu_start | npu_soft_rst | dma_start) && !s_axil_bvalid)
         n_nob++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
      int n;
      s_axil_awaddr  = a;
      s_axil_wdata   = d;
      s_axil_wstrb   = s;
      s_axil_awvalid = 1'b1;
      s_axil_wvalid  = 1'b1;
      s_axil_bready  = 1'b1;
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (s_axil_awready) break;
      end
      chk("aw_timeout", 32'(n >= 50), 32'd0);
      tick();
      s_axil_awvalid = 1'b0;
      s_axil_wvalid  = 1'b0;
      for (n = 0; n < 50; n++) begin
         if (s_axil_bvalid) break;
         tick();
      end
      resp = s_axil_bresp;
      tick();
      s_axil_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp);
      int n;
      s_axil_araddr  = a;
      s_axil_arvalid = 1'b1;
      s_axil_rready  = 1'b1;
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (s_axil_arready) break;
      end
      chk("ar_timeout", 32'(n >= 50), 32'd0);
      tick();
      s_axil_arvalid = 1'b0;
      for (n = 0; n < 50; n++) begin
         if (s_axil_rvalid) break;
         tick();
      end
      d    = s_axil_rdata;
      resp = s_axil_rresp;
      tick();
      s_axil_rready = 1'b0;
   endtask

   logic [31:0] rd, rd2;
   logic [1:0]  rs, rs2, ws;
   int          hi, n0;

   initial begin
      rst_n = 1'b0;
      s_axil_awaddr = '0; s_axil_awvalid = 1'b0;
      s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
      s_axil_bready = 1'b0;
      s_axil_araddr = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
      npu_busy = 1'b0; npu_done_evt = 1'b0; npu_err_evt = 1'b0;
      dma_busy = 1'b0; dma_done_evt = 1'b0;
      repeat (3) tick();
      chk("rst_ctl", {24'b0, s_axil_awready, s_axil_wready,
          s_axil_arready, s_axil_bvalid, s_axil_rvalid,
          npu_start, dma_start, irq}, 32'h0);
      chk("rst_resp", {28'b0, s_axil_bresp, s_axil_rresp}, 32'h0);
      chk("rst_rdata", s_axil_rdata, 32'h0);
      chk("rst_src", dma_src | dma_dst | {8'b0, dma_len}, 32'h0);
      rst_n = 1'b1;
      tick();

      axi_read(32'h010, rd, rs);
      chk("version", rd, 32'h0001_0000);
      chk("version_rr", {30'b0, rs}, 32'h0);
      axi_read(32'h014, rd, rs);
      chk("config", rd, 32'h0000_1010);

      axi_write(32'h108, 32'hDEAD_BEEF, 4'b0011, ws);
      chk("src_br", {30'b0, ws}, 32'h0);
      axi_read(32'h108, rd, rs);
      chk("src_rd", rd, 32'h0000_BEEF);
      chk("src_out", dma_src, 32'h0000_BEEF);
      axi_write(32'h110, 32'hFFFF_FFFF, 4'b1111, ws);
      axi_read(32'h110, rd, rs);
      chk("len_rd", rd, 32'h00FF_FFFF);
      chk("len_out", {8'b0, dma_len}, 32'h00FF_FFFF);

      fork
         axi_write(32'h10C, 32'h1234_5678, 4'b1100, ws);
         axi_read(32'h010, rd2, rs2);
      join
      chk("par_br", {30'b0, ws}, 32'h0);
      chk("par_rd", rd2, 32'h0001_0000);
      axi_read(32'h10C, rd, rs);
      chk("dst_rd", rd, 32'h1234_0000);
      chk("dst_out", dma_dst, 32'h1234_0000);

      axi_write(32'h000, 32'h1, 4'b0001, ws);
      chk("start_cnt", 32'(n_start), 32'd1);
      chk("pulse_nob", 32'(n_nob), 32'd0);
      axi_read(32'h000, rd, rs);
      chk("ctrl_rd", rd, 32'h0);
      axi_write(32'h000, 32'h2, 4'b0001, ws);
      chk("srst_cnt", 32'(n_srst), 32'd1);
      axi_write(32'h000, 32'h1, 4'b0000, ws);
      chk("start_nostrb", 32'(n_start), 32'd1);
      axi_write(32'h100, 32'h1, 4'b0001, ws);
      chk("dstart_cnt", 32'(n_dstart), 32'd1);
      chk("start_after", 32'(n_start), 32'd1);

      s_axil_awaddr = 32'h000; s_axil_wdata = 32'h1;
      s_axil_wstrb = 4'b0001;
      s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
      s_axil_bready = 1'b0;
      for (n0 = 0; n0 < 50; n0++) begin
         @(negedge clk);
         if (s_axil_awready) break;
      end
      tick();
      s_axil_awaddr = 32'h108; s_axil_wdata = 32'h1111_2222;
      s_axil_wstrb = 4'b1111;
      hi = 0;
      repeat (5) begin
         @(negedge clk);
         if (s_axil_awready) hi++;
      end
      chk("aw_hold", 32'(hi), 32'd0);
      chk("b_hold", {31'b0, s_axil_bvalid}, 32'd1);
      chk("hold_pulse", 32'(n_start), 32'd2);
      s_axil_bready = 1'b1;
      tick();
      @(negedge clk);
      chk("aw_free", {31'b0, s_axil_awready}, 32'd1);
      tick();
      axi_write(32'h108, 32'h1111_2222, 4'b1111, ws);
      chk("src_out2", dma_src, 32'h1111_2222);

      axi_write(32'h008, 32'h1, 4'b0001, ws);
      npu_done_evt = 1'b1;
      tick();
      npu_done_evt = 1'b0;
      chk("irq_lat", {31'b0, irq}, 32'd0);
      tick();
      chk("irq_set", {31'b0, irq}, 32'd1);
      axi_read(32'h00C, rd, rs);
      chk("ist_set", rd, 32'h1);
      fork
         begin
            npu_done_evt = 1'b1;
            tick();
            npu_done_evt = 1'b0;
         end
         axi_write(32'h00C, 32'h1, 4'b0001, ws);
      join
      axi_read(32'h00C, rd, rs);
      chk("ist_setwins", rd, 32'h1);
      chk("irq_keep", {31'b0, irq}, 32'd1);
      axi_write(32'h00C, 32'h1, 4'b0001, ws);
      axi_read(32'h00C, rd, rs);
      chk("ist_clr", rd, 32'h0);
      chk("irq_clr", {31'b0, irq}, 32'd0);

      npu_err_evt = 1'b1;
      tick();
      npu_err_evt = 1'b0;
      axi_read(32'h004, rd, rs);
      chk("status_err", rd, 32'h2);
      chk("irq_masked", {31'b0, irq}, 32'd0);
      axi_write(32'h00C, 32'h2, 4'b0000, ws);
      axi_read(32'h00C, rd, rs);
      chk("w1c_nostrb", rd, 32'h2);
      axi_write(32'h00C, 32'h2, 4'b0001, ws);
      axi_read(32'h004, rd, rs);
      chk("status_clr", rd, 32'h0);

      dma_busy = 1'b1;
      axi_read(32'h104, rd, rs);
      chk("dma_stat", rd, 32'h1);
      dma_busy = 1'b0;

      axi_write(32'h020, 32'h0, 4'b0000, ws);
      npu_busy = 1'b1;
      axi_read(32'h004, rd, rs);
      chk("status_busy", rd, 32'h1);
      axi_write(32'h020, 32'h0, 4'b1111, ws);
      repeat (100) tick();
      npu_busy = 1'b0;
      axi_read(32'h020, rd, rs);
      chk("perf_100", rd, 32'd101);
      axi_write(32'h020, 32'h5, 4'b0000, ws);
      axi_read(32'h020, rd, rs);
      chk("perf_clr", rd, 32'h0);

      force dut.r_perf_cnt = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.r_perf_cnt;
      tick();
      npu_busy = 1'b1;
      repeat (3) tick();
      npu_busy = 1'b0;
      axi_read(32'h020, rd, rs);
      chk("perf_wrap", rd, 32'h1);

      axi_write(32'h0FC, 32'h1234, 4'b1111, ws);
      chk("unmap_br", {30'b0, ws}, 32'h2);
      axi_read(32'h0FC, rd, rs);
      chk("unmap_rr", {30'b0, rs}, 32'h2);
      chk("unmap_rd", rd, 32'h0);

      s_axil_araddr = 32'h108;
      s_axil_arvalid = 1'b1;
      s_axil_rready = 1'b0;
      for (n0 = 0; n0 < 50; n0++) begin
         @(negedge clk);
         if (s_axil_arready) break;
      end
      tick();
      s_axil_arvalid = 1'b0;
      chk("rv_pend", {31'b0, s_axil_rvalid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_rv", {31'b0, s_axil_rvalid}, 32'd0);
      chk("rst_src2", dma_src, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      axi_read(32'h108, rd, rs);
      chk("post_src", rd, 32'h0);
      axi_read(32'h008, rd, rs);
      chk("post_ien", rd, 32'h0);
      axi_read(32'h10C, rd, rs);
      chk("post_dst", rd, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
